// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue: 1-cycle latency (0 with FETCH_BUFFER_BYPASS_EN when empty), DEPTH entries.
// Fetch is stalled via enq_ready when full or flushing; decode sees a NOP bubble whenever nothing is valid.
module fetch_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [DATA_WIDTH-1:0]        enq_instr,
  input  logic [DATA_WIDTH-1:0]        enq_pc,
  input  logic [DATA_WIDTH-1:0]        enq_pc4,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [DATA_WIDTH-1:0]        deq_instr,
  output logic [DATA_WIDTH-1:0]        deq_pc,
  output logic [DATA_WIDTH-1:0]        deq_pc4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc4;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_empty;
  logic            w_full;
  logic            w_bypass;
  logic            w_enq;
  logic            w_deq;
  logic            w_store;
  logic            w_pop;
  entry_t          w_enq_entry;
  entry_t          w_head;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_enq_entry = '{instr: enq_instr, pc: enq_pc, pc4: enq_pc4};

`ifdef FETCH_BUFFER_BYPASS_EN
  assign w_bypass = w_empty && enq_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign enq_ready = !w_full && !flush;
  assign deq_valid = (!w_empty && !flush) || w_bypass;

  assign w_enq = enq_valid && enq_ready;
  assign w_deq = deq_valid && deq_ready;
  // A bypassed entry consumed this cycle never touches the array.
  assign w_store = w_enq && !(w_bypass && deq_ready);
  assign w_pop   = w_deq && !w_bypass;

  assign w_head    = w_bypass ? w_enq_entry : r_mem[r_rd_ptr];
  assign deq_instr = deq_valid ? w_head.instr : NOP;
  assign deq_pc    = deq_valid ? w_head.pc    : '0;
  assign deq_pc4   = deq_valid ? w_head.pc4   : '0;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_store) - CW'(w_pop);
    end
  end

  // Contents survive flush/reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= w_enq_entry;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboarded bench for fetch_buffer (DEPTH=4); follows FETCH_BUFFER_BYPASS_EN when defined.
module tb_fetch_buffer;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, enq_valid, enq_ready, deq_valid, deq_ready;
  logic [DW-1:0] enq_instr, enq_pc, enq_pc4, deq_instr, deq_pc, deq_pc4;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  fetch_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_instr(enq_instr), .enq_pc(enq_pc), .enq_pc4(enq_pc4),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_pc4(deq_pc4),
    .count(count)
  );

  function automatic logic [DW-1:0] mk_instr(input logic [DW-1:0] pc);
    return {pc[15:0], 16'h0033} ^ 32'h5A00_0000;
  endfunction

  // Inputs change just after posedge; outputs are observed at the following negedge.
  task automatic drive(input bit ev, input logic [DW-1:0] pc, input bit dr, input bit fl);
    enq_valid = ev; enq_pc = pc; enq_pc4 = pc + 32'd4; enq_instr = mk_instr(pc);
    deq_ready = dr; flush = fl;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0); tick;
    tick;
    rst = 1'b0;
    sb.delete();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %b exp 0", deq_valid); end
    checks++; if (deq_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_nop: got %h exp 00000013", deq_instr); end
    checks++; if (deq_pc !== '0 || deq_pc4 !== '0) begin errors++; $display("FAIL reset_pc: got %h/%h exp 0/0", deq_pc, deq_pc4); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b exp 1", enq_ready); end
    tick;
  endtask

  task automatic test_fill_full;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(4*i), 1'b0, 1'b0);
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b exp 1", i, enq_ready); end
      checks++; if (count !== CW'(sb.size())) begin errors++; $display("FAIL fill_count_%0d: got %0d exp %0d", i, count, sb.size()); end
      sb.push_back(DW'(4*i));
      tick;
    end
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d exp %0d", count, DEPTH); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready: got %b exp 0", enq_ready); end
    checks++; if (deq_valid !== 1'b1 || deq_pc !== sb[0]) begin errors++; $display("FAIL full_head: got %b/%h exp 1/%h", deq_valid, deq_pc, sb[0]); end
    tick;
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_reject_count: got %0d exp %0d", count, DEPTH); end
    tick;
  endtask

  task automatic test_drain;
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (count !== CW'(sb.size())) begin errors++; $display("FAIL drain_count_%0d: got %0d exp %0d", i, count, sb.size()); end
      exp = sb.pop_front();
      checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL drain_valid_%0d: got %b exp 1", i, deq_valid); end
      checks++;
      if (deq_pc !== exp || deq_pc4 !== exp + 32'd4 || deq_instr !== mk_instr(exp)) begin
        errors++; $display("FAIL drain_data_%0d: got %h/%h/%h exp %h/%h/%h", i, deq_pc, deq_pc4, deq_instr, exp, exp + 32'd4, mk_instr(exp));
      end
      tick;
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (deq_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL drain_empty: got valid %b count %0d exp 0/0", deq_valid, count); end
    checks++; if (deq_instr !== 32'h0000_0013 || deq_pc !== '0) begin errors++; $display("FAIL drain_bubble: got %h/%h exp 00000013/0", deq_instr, deq_pc); end
    tick;
  endtask

  // Generic streaming step list: n enqueues from base, dequeue always enabled.
  task automatic test_stream_wrap;
    logic [DW-1:0] exp, pc;
    bit ev, exp_vld;
    int sz;
    for (int i = 0; i <= 10; i++) begin
      ev = (i < 10);
      pc = 32'h100 + DW'(4*i);
      drive(ev, pc, 1'b1, 1'b0);
      sz = sb.size();
      exp_vld = (sz != 0) || (BYP && ev);
      checks++; if (count !== CW'(sz)) begin errors++; $display("FAIL stream_count_%0d: got %0d exp %0d", i, count, sz); end
      checks++; if (deq_valid !== exp_vld) begin errors++; $display("FAIL stream_valid_%0d: got %b exp %b", i, deq_valid, exp_vld); end
      if (ev) sb.push_back(pc);
      if (exp_vld) begin
        exp = sb.pop_front();
        checks++; if (deq_pc !== exp || deq_instr !== mk_instr(exp)) begin errors++; $display("FAIL stream_data_%0d: got %h/%h exp %h/%h", i, deq_pc, deq_instr, exp, mk_instr(exp)); end
      end
      tick;
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== CW'(sb.size()) || deq_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got count %0d valid %b exp %0d/0", count, deq_valid, sb.size()); end
    tick;
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + DW'(4*i), 1'b0, 1'b0);
      sb.push_back(32'h300 + DW'(4*i));
      tick;
    end
    drive(1'b1, 32'h30C, 1'b1, 1'b1);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d exp 3", count); end
    checks++; if (deq_valid !== 1'b0 || enq_ready !== 1'b0) begin errors++; $display("FAIL flush_handshake: got valid %b ready %b exp 0/0", deq_valid, enq_ready); end
    checks++; if (deq_instr !== 32'h0000_0013) begin errors++; $display("FAIL flush_nop: got %h exp 00000013", deq_instr); end
    tick;
    sb.delete();
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    checks++; if (count !== '0) begin errors++; $display("FAIL flush_post_count: got %0d exp 0", count); end
    checks++; if (deq_valid !== BYP) begin errors++; $display("FAIL flush_post_valid: got %b exp %b", deq_valid, BYP); end
    sb.push_back(32'h200);
    tick;
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (deq_valid !== 1'b1 || deq_pc !== sb[0] || count !== 3'd1) begin errors++; $display("FAIL flush_first_out: got %b/%h/%0d exp 1/%h/1", deq_valid, deq_pc, count, sb[0]); end
    void'(sb.pop_front());
    tick;
  endtask

  task automatic test_bypass;
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    if (BYP) begin
      checks++; if (deq_valid !== 1'b1 || deq_pc !== 32'h40 || deq_pc4 !== 32'h44) begin errors++; $display("FAIL bypass_same_cycle: got %b/%h/%h exp 1/40/44", deq_valid, deq_pc, deq_pc4); end
      tick;
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (count !== '0 || deq_valid !== 1'b0) begin errors++; $display("FAIL bypass_not_stored: got count %0d valid %b exp 0/0", count, deq_valid); end
    end else begin
      checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL latency_same_cycle: got %b exp 0", deq_valid); end
      tick;
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (deq_valid !== 1'b1 || deq_pc !== 32'h40) begin errors++; $display("FAIL latency_next_cycle: got %b/%h exp 1/40", deq_valid, deq_pc); end
    end
    tick;
  endtask

  // Full buffer with simultaneous dequeue: enqueue still refused, head leaves.
  task automatic test_back_to_back;
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h500 + DW'(4*i), 1'b0, 1'b0);
      sb.push_back(32'h500 + DW'(4*i));
      tick;
    end
    drive(1'b1, 32'h510, 1'b1, 1'b0);
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_deq_ready: got %b exp 0", enq_ready); end
    exp = sb.pop_front();
    checks++; if (deq_pc !== exp) begin errors++; $display("FAIL full_deq_head: got %h exp %h", deq_pc, exp); end
    tick;
    while (sb.size() != 0) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      checks++; if (count !== CW'(sb.size())) begin errors++; $display("FAIL b2b_count: got %0d exp %0d", count, sb.size()); end
      exp = sb.pop_front();
      checks++; if (deq_valid !== 1'b1 || deq_pc !== exp) begin errors++; $display("FAIL b2b_data: got %b/%h exp 1/%h", deq_valid, deq_pc, exp); end
      tick;
    end
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h600 + DW'(4*i), 1'b0, 1'b0);
      tick;
    end
    rst = 1'b1;
    drive(1'b1, 32'h700, 1'b1, 1'b1);
    tick;
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== '0 || deq_valid !== 1'b0) begin errors++; $display("FAIL midreset: got count %0d valid %b exp 0/0", count, deq_valid); end
    tick;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_instr = '0; enq_pc = '0; enq_pc4 = '0;
    test_reset;
    test_fill_full;
    test_drain;
    test_stream_wrap;
    test_flush;
    test_bypass;
    test_back_to_back;
    test_reset_midstream;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

- Parametrised instruction queue that replaces the single-entry fetch/decode pipeline register.
- Holds up to DEPTH fetched instructions, each with its PC and PC+4, in a circular buffer between the fetch stage and the decode stage.
- Uses valid/ready handshakes on both sides, so fetch can run ahead of a stalled decode.
- Supports a single-cycle flush for taken branches and jumps resolved in execute.

## Interface
- DATA_WIDTH, 32, width of instruction, PC and PC+4 fields
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all held entries (branch/jump redirect)
- enq_valid  input  1  fetch presents an instruction
- enq_ready  output  1  buffer can accept this cycle
- enq_instr  input  DATA_WIDTH  fetched instruction
- enq_pc  input  DATA_WIDTH  PC of the instruction
- enq_pc4  input  DATA_WIDTH  PC+4 of the instruction
- deq_valid  output  1  head entry is valid for decode
- deq_ready  input  1  decode consumes the head this cycle
- deq_instr  output  DATA_WIDTH  head instruction
- deq_pc  output  DATA_WIDTH  head PC
- deq_pc4  output  DATA_WIDTH  head PC+4
- count  output  $clog2(DEPTH+1)  number of held entries

## Operation
- **Storage:** circular array of DEPTH entries, each {instr, pc, pc4}.
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Occupancy register count.
- **Enqueue handshake:** occurs when enq_valid && enq_ready.
  - Entry written at wr_ptr; wr_ptr increments.
- **Dequeue handshake:** occurs when deq_valid && deq_ready.
  - rd_ptr increments.
- **Ready/valid rules:**
  - enq_ready = (count != DEPTH) && !flush. A full buffer never accepts, even if a dequeue happens the same cycle.
  - deq_valid = (count != 0) && !flush.
- **Count update:** simultaneous enqueue and dequeue with 0 < count < DEPTH leaves count unchanged and advances both pointers.
- **Empty outputs:** when deq_valid = 0, deq_instr = 32'h0000_0013 (ADDI x0,x0,0 NOP), deq_pc = 0, deq_pc4 = 0. Decode therefore sees a bubble, never stale data.
- **Flush:** has priority over every handshake.
  - In the flush cycle, no enqueue or dequeue is counted.
  - Next cycle: count = 0, wr_ptr = rd_ptr = 0.
  - Entry contents are not cleared.
- **Protocol:** enq_valid and enq_instr are not required to be held by fetch; the buffer samples only on a handshake.

## Timing
- **Reset (next edge with rst = 1):**
  - count = 0, pointers = 0.
  - Outputs: deq_valid = 0, deq_instr = NOP, deq_pc = 0, deq_pc4 = 0, enq_ready = 1 (once rst = 0 and flush = 0).
  - Reset mid-stream drops all entries and dominates flush.
- **Latency:** an enqueued entry appears on deq_* with deq_valid = 1 one cycle after the enqueue edge (without bypass).
- **Throughput:** one enqueue and one dequeue per cycle sustained when 0 < count < DEPTH.
- **Pointer wrap:** wr_ptr = DEPTH-1 wraps to 0. Full and empty are distinguished only by count.
- **Output path:** deq_* is a combinational read of the entry at rd_ptr; no additional register stage.

## Configuration
- Macro: FETCH_BUFFER_BYPASS_EN.
- **Defined:** when count == 0, enq_valid = 1 and flush = 0:
  - deq_valid = 1 and deq_* = enq_* combinationally, giving 0-cycle latency.
  - If deq_ready = 1, the entry is consumed and not stored; count stays 0.
  - Otherwise it is stored normally.
- **Undefined:** no combinational enq→deq path; minimum latency 1 cycle.

## Test plan
- **Reset:** rst high 2 cycles, then low → count = 0, deq_valid = 0, deq_instr = 32'h00000013, enq_ready = 1.
- **Fill to full:** DEPTH = 4, enqueue pc = 0x0, 0x4, 0x8, 0xC with deq_ready = 0 → count = 4, enq_ready = 0; a fifth enq_valid is not accepted and count stays 4.
- **Drain in order:** from full, deq_ready = 1 for 4 cycles → deq_pc = 0x0, 0x4, 0x8, 0xC with deq_pc4 = pc + 4; then deq_valid = 0 and count = 0.
- **Streaming and wrap:** enqueue and dequeue every cycle for 10 instructions starting at pc = 0x100 → count holds at 1 after the first cycle, output order preserved across the pointer wrap, no gaps.
- **Flush with simultaneous events:** count = 3, assert flush with enq_valid = 1 and deq_ready = 1 → in that cycle deq_valid = 0 and enq_ready = 0; next cycle count = 0; the subsequent enqueue of pc = 0x200 is the first entry output.
- **Bypass:** with FETCH_BUFFER_BYPASS_EN, buffer empty, enq pc = 0x40 with deq_ready = 1 → deq_valid = 1 and deq_pc = 0x40 in the same cycle, count stays 0. Without the macro → deq_valid = 0 that cycle, then deq_pc = 0x40 the next cycle.
